// File: rtl/pipeline_hazard_ctrl.sv
// Hazard scheduler for a 5-stage pipeline: shadow scoreboard of E/M/W plus forwarding and stall/flush control.
// Define HAZARD_PERF_CNT_EN to add the saturating stall_cycles / flush_events counters.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_d,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rd_d,
  input  logic                  reg_write_d,
  input  logic [1:0]            result_src_d,
  input  logic                  mem_access_d,
  input  logic                  pc_src_e,
  input  logic                  dmem_ready,
  output logic [1:0]            forward_a_e,
  output logic [1:0]            forward_b_e,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  stall_e,
  output logic                  stall_m,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic                  flush_w
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events
`endif
);

  logic [REG_ADDR_W-1:0] rs1_e_q, rs1_e_d;
  logic [REG_ADDR_W-1:0] rs2_e_q, rs2_e_d;
  logic [REG_ADDR_W-1:0] rd_e_q, rd_e_d;
  logic                  reg_write_e_q, reg_write_e_d;
  logic                  is_load_e_q, is_load_e_d;
  logic                  mem_access_e_q, mem_access_e_d;

  logic [REG_ADDR_W-1:0] rd_m_q, rd_m_d;
  logic                  reg_write_m_q, reg_write_m_d;
  logic                  mem_access_m_q, mem_access_m_d;

  logic [REG_ADDR_W-1:0] rd_w_q, rd_w_d;
  logic                  reg_write_w_q, reg_write_w_d;

  logic mem_stall;
  logic lw_stall;

  // Source x0 never forwards; M beats W because it holds the younger result.
  function automatic logic [1:0] fwd_select(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] rd_m,
    input logic                  rw_m,
    input logic [REG_ADDR_W-1:0] rd_w,
    input logic                  rw_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != '0) begin
      if (rw_m && (rd_m == rs)) begin
        sel = 2'b10;
      end else if (rw_w && (rd_w == rs)) begin
        sel = 2'b01;
      end
    end
    return sel;
  endfunction

  always_comb begin
    forward_a_e = fwd_select(rs1_e_q, rd_m_q, reg_write_m_q, rd_w_q, reg_write_w_q);
    forward_b_e = fwd_select(rs2_e_q, rd_m_q, reg_write_m_q, rd_w_q, reg_write_w_q);
  end

  always_comb begin
    mem_stall = mem_access_m_q & ~dmem_ready;
    lw_stall  = is_load_e_q & valid_d & (rd_e_q != '0) &
                ((rd_e_q == rs1_d) | (rd_e_q == rs2_d));
  end

  // A pending memory wait freezes everything, so a taken branch waits in E until it clears.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (mem_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (pc_src_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lw_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_comb begin
    rs1_e_d        = rs1_e_q;
    rs2_e_d        = rs2_e_q;
    rd_e_d         = rd_e_q;
    reg_write_e_d  = reg_write_e_q;
    is_load_e_d    = is_load_e_q;
    mem_access_e_d = mem_access_e_q;
    if (flush_e) begin
      rs1_e_d        = '0;
      rs2_e_d        = '0;
      rd_e_d         = '0;
      reg_write_e_d  = 1'b0;
      is_load_e_d    = 1'b0;
      mem_access_e_d = 1'b0;
    end else if (!stall_e) begin
      // An invalid D slot enters E as a bubble.
      rs1_e_d        = valid_d ? rs1_d : '0;
      rs2_e_d        = valid_d ? rs2_d : '0;
      rd_e_d         = valid_d ? rd_d : '0;
      reg_write_e_d  = valid_d & reg_write_d;
      is_load_e_d    = valid_d & (result_src_d == 2'b01);
      mem_access_e_d = valid_d & mem_access_d;
    end
  end

  always_comb begin
    rd_m_d         = rd_m_q;
    reg_write_m_d  = reg_write_m_q;
    mem_access_m_d = mem_access_m_q;
    if (!stall_m) begin
      rd_m_d         = rd_e_q;
      reg_write_m_d  = reg_write_e_q;
      mem_access_m_d = mem_access_e_q;
    end
  end

  always_comb begin
    rd_w_d        = rd_m_q;
    reg_write_w_d = reg_write_m_q;
    if (flush_w) begin
      rd_w_d        = '0;
      reg_write_w_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs1_e_q        <= '0;
      rs2_e_q        <= '0;
      rd_e_q         <= '0;
      reg_write_e_q  <= 1'b0;
      is_load_e_q    <= 1'b0;
      mem_access_e_q <= 1'b0;
      rd_m_q         <= '0;
      reg_write_m_q  <= 1'b0;
      mem_access_m_q <= 1'b0;
      rd_w_q         <= '0;
      reg_write_w_q  <= 1'b0;
    end else begin
      rs1_e_q        <= rs1_e_d;
      rs2_e_q        <= rs2_e_d;
      rd_e_q         <= rd_e_d;
      reg_write_e_q  <= reg_write_e_d;
      is_load_e_q    <= is_load_e_d;
      mem_access_e_q <= mem_access_e_d;
      rd_m_q         <= rd_m_d;
      reg_write_m_q  <= reg_write_m_d;
      mem_access_m_q <= mem_access_m_d;
      rd_w_q         <= rd_w_d;
      reg_write_w_q  <= reg_write_w_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_events_q, flush_events_d;

  // Both counters stick at all-ones instead of wrapping.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (stall_f && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
    if (flush_d && (flush_events_q != '1)) begin
      flush_events_d = flush_events_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Table-driven bench for pipeline_hazard_ctrl with an expected-value queue and an async-reset sequence.
module tb_pipeline_hazard_ctrl;
  localparam int AW = 5;
  localparam int CW = 32;

  // Expected output packing: {fwd_a[1:0], fwd_b[1:0], stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}
  localparam logic [10:0] E_IDLE  = 11'b0000_0000_000;
  localparam logic [10:0] E_LWS   = 11'b0000_1100_010;
  localparam logic [10:0] E_BR    = 11'b0000_0000_110;
  localparam logic [10:0] E_MEM   = 11'b0000_1111_001;
  localparam logic [10:0] E_FA01  = 11'b0100_0000_000;
  localparam logic [10:0] E_F1010 = 11'b1010_0000_000;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_d;
  logic [AW-1:0] rs1_d, rs2_d, rd_d;
  logic          reg_write_d;
  logic [1:0]    result_src_d;
  logic          mem_access_d;
  logic          pc_src_e;
  logic          dmem_ready;
  logic [1:0]    forward_a_e, forward_b_e;
  logic          stall_f, stall_d, stall_e, stall_m;
  logic          flush_d, flush_e, flush_w;
`ifdef HAZARD_PERF_CNT_EN
  logic [CW-1:0] stall_cycles, flush_events;
`endif

  pipeline_hazard_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .valid_d(valid_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .reg_write_d(reg_write_d), .result_src_d(result_src_d), .mem_access_d(mem_access_d),
    .pc_src_e(pc_src_e), .dmem_ready(dmem_ready),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [AW-1:0] rd;
    logic          rw;
    logic [1:0]    rsrc;
    logic          mem;
    logic          pc;
    logic          rdy;
    logic [10:0]   exp;
  } vec_t;

  vec_t        vecs[$];
  logic [10:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;
  int          exp_sc = 0;
  int          exp_fe = 0;

  function automatic vec_t mk(input logic v, input int rs1, input int rs2, input int rd,
                              input logic rw, input logic [1:0] rsrc, input logic mem,
                              input logic pc, input logic rdy, input logic [10:0] exp);
    vec_t t;
    t.v = v; t.rs1 = AW'(rs1); t.rs2 = AW'(rs2); t.rd = AW'(rd);
    t.rw = rw; t.rsrc = rsrc; t.mem = mem; t.pc = pc; t.rdy = rdy; t.exp = exp;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    valid_d = t.v; rs1_d = t.rs1; rs2_d = t.rs2; rd_d = t.rd;
    reg_write_d = t.rw; result_src_d = t.rsrc; mem_access_d = t.mem;
    pc_src_e = t.pc; dmem_ready = t.rdy;
  endtask

  task automatic check(input string name);
    logic [10:0] want;
    logic [10:0] got;
    got = {forward_a_e, forward_b_e, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard queue empty, got=%b", name, got);
      return;
    end
    want = exp_q.pop_front();
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%b want=%b", name, got, want);
    end else begin
      $display("%s: outputs=%b ok", name, got);
    end
`ifdef HAZARD_PERF_CNT_EN
    total++;
    if ((stall_cycles !== CW'(exp_sc)) || (flush_events !== CW'(exp_fe))) begin
      bad++;
      $display("FAIL %s_cnt: got stall=%0d flush=%0d want stall=%0d flush=%0d",
               name, stall_cycles, flush_events, exp_sc, exp_fe);
    end
`endif
    if (want[6]) exp_sc++;
    if (want[2]) exp_fe++;
  endtask

  initial begin
    reset = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, E_IDLE));

    // Load-use: lw x5 then add reading x5
    vecs.push_back(mk(0, 0, 0, 0,  0, 2'b00, 0, 0, 1, E_IDLE));
    vecs.push_back(mk(1, 1, 0, 5,  1, 2'b01, 1, 0, 1, E_IDLE));
    vecs.push_back(mk(1, 5, 7, 6,  1, 2'b00, 0, 0, 1, E_LWS));
    vecs.push_back(mk(1, 5, 7, 6,  1, 2'b00, 0, 0, 1, E_IDLE));
    vecs.push_back(mk(0, 0, 0, 0,  0, 2'b00, 0, 0, 1, E_FA01));
    // Two writers of x3, then a reader of x3 on both operands
    vecs.push_back(mk(1, 1, 2, 3,  1, 2'b00, 0, 0, 1, E_IDLE));
    vecs.push_back(mk(1, 4, 4, 3,  1, 2'b00, 0, 0, 1, E_IDLE));
    vecs.push_back(mk(1, 3, 3, 8,  1, 2'b00, 0, 0, 1, E_IDLE));
    vecs.push_back(mk(0, 0, 0, 0,  0, 2'b00, 0, 0, 1, E_F1010));
    // x0 writers, then x0 readers; lw x0 followed by an x0 reader
    vecs.push_back(mk(1, 1, 0, 0,  1, 2'b00, 0, 0, 1, E_IDLE));
    vecs.push_back(mk(1, 2, 0, 0,  1, 2'b00, 0, 0, 1, E_IDLE));
    vecs.push_back(mk(1, 0, 0, 9,  1, 2'b00, 0, 0, 1, E_IDLE));
    vecs.push_back(mk(1, 1, 0, 0,  1, 2'b01, 1, 0, 1, E_IDLE));
    vecs.push_back(mk(1, 0, 0, 10, 1, 2'b00, 0, 0, 1, E_IDLE));
    vecs.push_back(mk(0, 0, 0, 0,  0, 2'b00, 0, 0, 1, E_IDLE));
    // Branch beats load-use, then memory wait defers the branch for three cycles
    vecs.push_back(mk(1, 1, 0, 5,  1, 2'b01, 1, 0, 1, E_IDLE));
    vecs.push_back(mk(1, 5, 5, 6,  1, 2'b00, 0, 1, 1, E_BR));
    vecs.push_back(mk(1, 1, 2, 7,  1, 2'b00, 0, 1, 0, E_MEM));
    vecs.push_back(mk(1, 1, 2, 7,  1, 2'b00, 0, 1, 0, E_MEM));
    vecs.push_back(mk(1, 1, 2, 7,  1, 2'b00, 0, 1, 0, E_MEM));
    vecs.push_back(mk(1, 1, 2, 7,  1, 2'b00, 0, 1, 1, E_BR));
    // Store then load x4 into M/E, then two stalled cycles ahead of the async reset
    vecs.push_back(mk(1, 1, 2, 0,  0, 2'b00, 1, 0, 1, E_IDLE));
    vecs.push_back(mk(1, 1, 0, 4,  1, 2'b01, 1, 0, 1, E_IDLE));
    vecs.push_back(mk(1, 4, 0, 11, 1, 2'b00, 0, 0, 0, E_MEM));
    vecs.push_back(mk(1, 4, 0, 11, 1, 2'b00, 0, 0, 0, E_MEM));

    exp_q.push_back(E_IDLE);
    @(negedge clk);
    check("reset");
    #2 reset = 1'b0;
    exp_sc = 0;
    exp_fe = 0;

    foreach (vecs[i]) begin
      @(posedge clk);
      #1 drive(vecs[i]);
      exp_q.push_back(vecs[i].exp);
      @(negedge clk);
      check($sformatf("vec%0d", i));
    end

    // Reset mid memory stall with no clock edge; D still reads the load's rd
    @(posedge clk);
    #1 drive(vecs[vecs.size()-1]);
    #2 reset = 1'b1;
    exp_sc = 0;
    exp_fe = 0;
    exp_q.push_back(E_IDLE);
    @(negedge clk);
    check("async_reset");
    #2 reset = 1'b0;

    @(posedge clk);
    #1 drive(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, E_IDLE));
    exp_q.push_back(E_IDLE);
    @(negedge clk);
    check("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
